// File: rtl/life_pkg.sv
// Shared types, rule constants and the neighbour popcount for the life grid stepper.
package life_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  // Conway B3/S23 and the HighLife birth mask (B36)
  localparam logic [8:0] RULE_B3  = 9'b000001000;
  localparam logic [8:0] RULE_S23 = 9'b000001100;
  localparam logic [8:0] RULE_B36 = 9'b001001000;

  // Live-neighbour count, 0..8
  function automatic logic [3:0] neighbour_count(input logic [7:0] nbr);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, nbr[i]};
    return n;
  endfunction

endpackage

// File: rtl/life_rule_cell.sv
// One totalistic B/S rule evaluator: next state of a single cell from its 8 neighbours.
module life_rule_cell
  import life_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       cur,
  input  logic [8:0] birth_mask,
  input  logic [8:0] survive_mask,
  output logic       cell_new
);

  logic [3:0] n;

  // Live cells look up the survive mask, dead cells the birth mask
  always_comb begin
    n        = neighbour_count(nbr);
    cell_new = cur ? survive_mask[n] : birth_mask[n];
  end

endmodule

// File: rtl/life_grid_stepper.sv
// Register-resident WIDTH x HEIGHT life grid, advanced one row per cycle in place.
// saved_prev / saved_row0 keep the pre-update copies of rows already overwritten,
// so the in-place sweep equals a simultaneous update of the whole generation.
module life_grid_stepper
  import life_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [$clog2(HEIGHT)-1:0] load_addr,
  input  logic [WIDTH-1:0]          load_row,
  input  logic                      step_start,
  input  logic [CNT_W-1:0]          step_count,
  input  logic                      wrap_en,
  input  logic [8:0]                birth_mask,
  input  logic [8:0]                survive_mask,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          gen_count,
  input  logic [$clog2(HEIGHT)-1:0] rd_addr,
  output logic [WIDTH-1:0]          rd_row
);

  localparam int              RW   = $clog2(HEIGHT);
  localparam logic [RW-1:0]   LAST = RW'(HEIGHT - 1);
  localparam logic [RW:0]     HLIM = (RW + 1)'(HEIGHT);

  state_t                       state;
  logic [HEIGHT-1:0][WIDTH-1:0] grid;
  logic [WIDTH-1:0]             saved_prev, saved_row0;
  logic [WIDTH-1:0]             prev_row, cur_row, next_row, new_row;
  logic [RW-1:0]                row_idx;
  logic [CNT_W-1:0]             gens_left;
  logic                         sh_wrap;
  logic [8:0]                   sh_birth, sh_survive;

  assign load_ready = !busy;

  // Select the three rows around row_idx, applying the vertical edge rule
  always_comb begin
    cur_row  = grid[row_idx];
    prev_row = saved_prev;
    next_row = '0;
    if (row_idx == '0) prev_row = sh_wrap ? grid[HEIGHT-1] : '0;
    if (row_idx == LAST) begin
      if (sh_wrap) next_row = saved_row0;
    end else begin
      next_row = grid[row_idx + RW'(1)];
    end
  end

  // WIDTH parallel evaluators; horizontal edge columns are masked unless wrapping
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    localparam int CL = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int CR = (c == WIDTH - 1) ? 0 : c + 1;
    logic       lok, rok;
    logic [7:0] nbr;
    assign lok = (c != 0) || sh_wrap;
    assign rok = (c != WIDTH - 1) || sh_wrap;
    assign nbr = {prev_row[CL] & lok, prev_row[c], prev_row[CR] & rok,
                  cur_row[CL]  & lok,              cur_row[CR]  & rok,
                  next_row[CL] & lok, next_row[c], next_row[CR] & rok};
    life_rule_cell u_cell (
      .nbr          (nbr),
      .cur          (cur_row[c]),
      .birth_mask   (sh_birth),
      .survive_mask (sh_survive),
      .cell_new     (new_row[c])
    );
  end

  // Control FSM, grid storage, counters and the registered display read port
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grid       <= '0;
      saved_prev <= '0;
      saved_row0 <= '0;
      row_idx    <= '0;
      gens_left  <= '0;
      sh_wrap    <= 1'b0;
      sh_birth   <= '0;
      sh_survive <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gen_count  <= '0;
      rd_row     <= '0;
    end else begin
      rd_row <= ({1'b0, rd_addr} < HLIM) ? grid[rd_addr] : '0;
      done   <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (load_valid && ({1'b0, load_addr} < HLIM)) grid[load_addr] <= load_row;
          state <= IDLE;
          if (state == IDLE && step_start) begin
            sh_wrap    <= wrap_en;
            sh_birth   <= birth_mask;
            sh_survive <= survive_mask;
            row_idx    <= '0;
            gens_left  <= step_count;
            if (step_count == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          grid[row_idx] <= new_row;
          saved_prev    <= cur_row;
          if (row_idx == '0) saved_row0 <= cur_row;
          if (row_idx == LAST) begin
            row_idx   <= '0;
            gen_count <= gen_count + CNT_W'(1);
            gens_left <= gens_left - CNT_W'(1);
            if (gens_left == CNT_W'(1)) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            row_idx <= row_idx + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_grid_stepper.sv
// Directed bench for life_grid_stepper: table of whole-grid vectors plus corner sequences.
module tb_life_grid_stepper;
  import life_pkg::*;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid, load_ready;
  logic [3:0]    load_addr, rd_addr;
  logic [W-1:0]  load_row, rd_row;
  logic          step_start, wrap_en, busy, done;
  logic [CW-1:0] step_count, gen_count;
  logic [8:0]    birth_mask, survive_mask;

  always #5 clk = ~clk;

  life_grid_stepper #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_row(load_row), .step_start(step_start),
    .step_count(step_count), .wrap_en(wrap_en), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .busy(busy), .done(done), .gen_count(gen_count),
    .rd_addr(rd_addr), .rd_row(rd_row)
  );

  typedef struct {
    string                name;
    int                   steps;
    bit                   wrap;
    logic [8:0]           b;
    logic [8:0]           s;
    logic [H-1:0][W-1:0]  init;
    logic [H-1:0][W-1:0]  expg;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   failures = 0;
  int   gen_exp = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [W-1:0] r);
    load_valid = 1'b1;
    load_addr  = a[3:0];
    load_row   = r;
    tick;
    load_valid = 1'b0;
  endtask

  task automatic read_row(input int a, output logic [W-1:0] r);
    rd_addr = a[3:0];
    tick;
    r = rd_row;
  endtask

  function automatic vec_t mk(string n, int st, bit w, logic [8:0] b, logic [8:0] s);
    vec_t v;
    v.name = n; v.steps = st; v.wrap = w; v.b = b; v.s = s;
    v.init = '0; v.expg = '0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int done_cyc, busy_cnt, cyc;
    logic [W-1:0] r;
    for (int i = 0; i < H; i++) load(i, v.init[i]);
    step_count = CW'(v.steps); wrap_en = v.wrap; birth_mask = v.b; survive_mask = v.s;
    step_start = 1'b1;
    tick;
    step_start = 1'b0;
    // scramble the run parameters: the sampled copies must be used
    wrap_en = ~v.wrap; birth_mask = '1; survive_mask = '0; step_count = 16'h0003;
    cyc = 1; busy_cnt = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc <= H * v.steps + 20) begin
      if (busy) busy_cnt++;
      if (done) done_cyc = cyc;
      else begin
        tick;
        cyc++;
      end
    end
    check({v.name, " done_cycle"}, done_cyc, H * v.steps + 1);
    check({v.name, " busy_cycles"}, busy_cnt, H * v.steps);
    tick;
    check({v.name, " idle_after_done"}, {busy, done}, 2'b00);
    gen_exp += v.steps;
    check({v.name, " gen_count"}, gen_count, gen_exp[15:0]);
    for (int i = 0; i < H; i++) begin
      read_row(i, r);
      check($sformatf("%s row%0d", v.name, i), r, v.expg[i]);
    end
  endtask

  initial begin
    vec_t v;
    logic [W-1:0] r;
    int dn, dcyc;

    // hand-computed vectors
    v = mk("blinker1", 1, 0, RULE_B3, RULE_S23);
    v.init[5] = 16'h0070;
    v.expg[4] = 16'h0020; v.expg[5] = 16'h0020; v.expg[6] = 16'h0020;
    vq.push_back(v);
    v = mk("blinker2", 2, 0, RULE_B3, RULE_S23);
    v.init[5] = 16'h0070; v.expg = v.init;
    vq.push_back(v);
    v = mk("zero_steps", 0, 0, RULE_B3, RULE_S23);
    v.init[5] = 16'h0070; v.init[9] = 16'h8001; v.expg = v.init;
    vq.push_back(v);
    v = mk("glider_torus", 64, 1, RULE_B3, RULE_S23);
    v.init[0] = 16'h0002; v.init[1] = 16'h0004; v.init[2] = 16'h0007; v.expg = v.init;
    vq.push_back(v);
    v = mk("glider_corner", 64, 0, RULE_B3, RULE_S23);
    v.init[13] = 16'h4000; v.init[14] = 16'h8000; v.init[15] = 16'hE000;
    v.expg[14] = 16'hC000; v.expg[15] = 16'hC000;
    vq.push_back(v);
    v = mk("highlife_b6", 1, 0, RULE_B36, RULE_S23);
    v.init[7] = 16'h0380; v.init[9] = 16'h0380;
    for (int i = 6; i <= 10; i++) v.expg[i] = 16'h0100;
    vq.push_back(v);
    v = mk("conway_no_b6", 1, 0, RULE_B3, RULE_S23);
    v.init[7] = 16'h0380; v.init[9] = 16'h0380;
    v.expg[6] = 16'h0100; v.expg[7] = 16'h0100; v.expg[9] = 16'h0100; v.expg[10] = 16'h0100;
    vq.push_back(v);
    v = mk("hwrap_on", 1, 1, RULE_B3, RULE_S23);
    v.init[5] = 16'h8003;
    v.expg[4] = 16'h0001; v.expg[5] = 16'h0001; v.expg[6] = 16'h0001;
    vq.push_back(v);
    v = mk("hwrap_off", 1, 0, RULE_B3, RULE_S23);
    v.init[5] = 16'h8003;
    vq.push_back(v);
    v = mk("vwrap_on", 1, 1, RULE_B3, RULE_S23);
    v.init[15] = 16'h0020; v.init[0] = 16'h0020; v.init[1] = 16'h0020;
    v.expg[0] = 16'h0070;
    vq.push_back(v);

    // reset state
    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_row = '0; step_start = 1'b0;
    step_count = '0; wrap_en = 1'b0; birth_mask = RULE_B3; survive_mask = RULE_S23; rd_addr = 4'd5;
    tick; tick;
    check("reset busy/done", {busy, done}, 2'b00);
    check("reset load_ready", load_ready, 1'b1);
    check("reset gen_count", gen_count, 0);
    check("reset rd_row", rd_row, 0);
    reset = 1'b0;

    foreach (vq[k]) run_vec(vq[k]);

    // load and start while busy are ignored; a load in FINISH is accepted
    for (int i = 0; i < H; i++) load(i, (i == 5) ? 16'h0070 : 16'h0000);
    step_count = 16'd1; wrap_en = 1'b0; birth_mask = RULE_B3; survive_mask = RULE_S23;
    step_start = 1'b1;
    tick;
    dn = 0; dcyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step_start = (cyc == 5);
      step_count = 16'd5;
      load_valid = (cyc == 3);
      load_addr  = 4'd0;
      load_row   = 16'hFFFF;
      if (cyc == 3) check("load_ready low in run", load_ready, 1'b0);
      if (done) begin
        dn++;
        if (dn == 1) begin
          dcyc = cyc;
          check("load_ready in finish", load_ready, 1'b1);
          load_valid = 1'b1; load_addr = 4'd3; load_row = 16'hABCD;
        end
      end
      tick;
    end
    step_start = 1'b0; load_valid = 1'b0;
    gen_exp += 1;
    check("busy_run done pulses", dn, 1);
    check("busy_run done cycle", dcyc, H + 1);
    check("busy_run gen_count", gen_count, gen_exp[15:0]);
    read_row(0, r); check("busy_run row0 not loaded", r, 16'h0000);
    read_row(3, r); check("finish load row3", r, 16'hABCD);
    read_row(5, r); check("busy_run row5", r, 16'h0020);

    // reset mid-run aborts without a done pulse
    step_count = 16'd2; step_start = 1'b1;
    tick;
    step_start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check("busy before reset", busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid-reset busy/done", {busy, done}, 2'b00);
    check("mid-reset gen_count", gen_count, 0);
    check("mid-reset rd_row", rd_row, 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dn++;
      tick;
    end
    check("no activity after reset", dn, 0);
    for (int i = 0; i < H; i++) begin
      read_row(i, r);
      check($sformatf("post-reset row%0d", i), r, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_grid_stepper.md
Name: life_grid_stepper

Overview:
- Parametrised successor to the single-cell evolution block. It holds a WIDTH x HEIGHT Game-of-Life grid in registers and advances it N generations on command.
- It computes one full row per cycle with WIDTH parallel rule evaluators.
- Birth/survive rules are programmable (any B/S totalistic rule), and the grid edge can be dead or toroidal.
- It sits between the host/loader (row writes), the display scanner (row reads) and the control FSM (start/done).

Parameters:
- WIDTH, 16, cells per row (>=3).
- HEIGHT, 16, number of rows (>=3).
- CNT_W, 16, width of step_count and gen_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  write one grid row this cycle.
- load_ready  out  1  equals !busy; a write is accepted only when load_valid && load_ready.
- load_addr  in  $clog2(HEIGHT)  row index to write.
- load_row  in  WIDTH  row data; bit c is column c, 1 = alive.
- step_start  in  1  one-cycle request to run step_count generations.
- step_count  in  CNT_W  number of generations to run.
- wrap_en  in  1  0 = cells outside the grid are dead; 1 = toroidal edges.
- birth_mask  in  9  bit n set means a dead cell with n live neighbours is born.
- survive_mask  in  9  bit n set means a live cell with n live neighbours survives.
- busy  out  1  high while generations are being computed.
- done  out  1  one-cycle pulse when the run completes.
- gen_count  out  CNT_W  total generations computed since reset; wraps modulo 2^CNT_W.
- rd_addr  in  $clog2(HEIGHT)  display read row index.
- rd_row  out  WIDTH  registered grid[rd_addr], valid one cycle after rd_addr.

Behaviour:
- Reset: grid all 0, state IDLE, busy=0, done=0, gen_count=0, rd_row=0, internal counters 0. Reset mid-run aborts the run immediately and emits no done pulse.
- States:
  - IDLE: busy=0, load_ready=1. Accepted loads write grid[load_addr] at the clock edge. load_addr >= HEIGHT is ignored.
  - step_start in IDLE samples step_count, wrap_en, birth_mask and survive_mask into shadow registers. Later changes on these inputs have no effect until the next start.
  - step_count==0: go to FINISH, and the grid is unchanged.
  - Otherwise go to RUN with row_idx=0 and gens_left=step_count.
  - RUN: busy=1, load_ready=0, loads ignored. Each cycle computes new row r=row_idx:
    - prev: r==0 ? (wrap ? grid[HEIGHT-1] : 0) : saved_prev.
    - cur: grid[r].
    - next: r==HEIGHT-1 ? (wrap ? saved_row0 : 0) : grid[r+1].
    - Column neighbours at c-1 and c+1 use the same wrap rule: wrapped when wrap_en, 0 otherwise.
    - Write grid[r]=new row, saved_prev=old grid[r]. When r==0 also set saved_row0=old grid[0].
    - The update is in place and equals a simultaneous update of the whole generation.
    - At r==HEIGHT-1: gen_count++, gens_left--, row_idx=0. If gens_left reaches 0, go to FINISH; otherwise the next generation starts on the next cycle with no bubble.
  - FINISH: one cycle with done=1, busy=0, then IDLE. load_ready=1 in FINISH; a load there is accepted. step_start in FINISH is ignored.
- Latency: step_start at cycle t gives busy=1 on cycles t+1 .. t+HEIGHT*N, and done=1 on cycle t+HEIGHT*N+1. For N=0, done=1 on cycle t+1.
- step_start while busy is ignored (no queuing).
- Rule: n = popcount of the 8 neighbours, 0..8, 4-bit. new = cur ? survive_mask[n] : birth_mask[n].
- rd_row: registered every cycle regardless of state. While busy it shows rows mid-update; the consumer reads only in IDLE.

Decomposition:
- Package life_pkg:
  - state enum {IDLE, RUN, FINISH}.
  - RULE_B3 = 9'b000001000 and RULE_S23 = 9'b000001100 (Conway defaults).
  - RULE_B36 = 9'b001001000 (HighLife birth mask).
  - function neighbour_count(8-bit) returning 4 bits.
- Sub-module life_rule_cell: inputs 8 neighbour bits, cur, birth_mask, survive_mask; output new. It generalises the single-cell evolution block and is instantiated WIDTH times via generate.

Test Plan:
- Blinker, 16x16, wrap=0, Conway rule: load row5 = cols 4..6, step_count=1 -> rows 4,5,6 each have only col5 set. busy is high for exactly 16 cycles; done is on cycle t+17; gen_count=1.
- Blinker period: same load, step_count=2 -> grid identical to the load; done on cycle t+33; gen_count=2.
- Toroidal glider: glider at rows 0..2, wrap=1, step_count=64 -> grid equals the initial glider (shift of 16,16 wraps back); gen_count=64. With wrap=0 and a glider aimed at the corner, step_count=64 -> no glider remains at its start position and no cells appear on the opposite edges.
- Programmable rule: birth=RULE_B36, survive=RULE_S23; a dead cell at (8,8) with neighbours (7,7),(7,8),(7,9),(9,7),(9,8),(9,9) -> (8,8) becomes 1 after one step, whereas Conway leaves it 0.
- Zero steps and loading while busy: step_count=0 -> done on cycle t+1, grid unchanged, gen_count unchanged. A load_valid during RUN sees load_ready=0 and the row is not written. step_start during RUN is ignored, and exactly one done pulse occurs.
- Reset mid-run: assert reset at busy cycle 5 -> next cycle busy=0, done=0, gen_count=0, all rd_row reads return 0, and no done pulse follows.
